bit_serializer: RTL



---
 rtl/bit_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial converter. Accepts WIDTH-bit words on the id side and
//   emits them one bit per accepted beat on the sd side, MSB first or LSB
//   first depending on MSB_FIRST. A one-word holding register lets the next
//   word wait behind the word being shifted, so words stream back to back
//   with no idle beat between them.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both 1. The producer keeps data stable while valid is
//   high and ready is low. id_ready does not depend on id_valid, and
//   sd_valid/sd/sd_first/sd_last do not depend on sd_ready.
//
// Ports:
//   clk       system clock, rising edge
//   nrst      asynchronous active-low reset
//   id        parallel input word
//   id_valid  id holds a valid word
//   id_ready  a word can be accepted this cycle (hold register empty)
//   sd        serial data bit
//   sd_valid  sd holds a valid bit
//   sd_ready  downstream consumes sd this cycle
//   sd_first  sd is the first bit of a word
//   sd_last   sd is the last bit of a word
//   busy      a word is held or being shifted
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] id,
    input  logic             id_valid,
    output logic             id_ready,
    output logic             sd,
    output logic             sd_valid,
    input  logic             sd_ready,
    output logic             sd_first,
    output logic             sd_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh;
    logic             sh_busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    logic             beat;
    logic             word_end;
    logic             accept;
    logic             load_sh;
    logic             load_hold;
    logic [WIDTH-1:0] sh_shifted;
    logic             sh_out;

    assign beat     = sh_busy & sd_ready;
    assign word_end = beat & (cnt == LAST_CNT);
    assign accept   = id_valid & ~hold_full;
    // A word goes straight into the shifter when it is idle, or when the
    // current word finishes this cycle (hold is necessarily empty then,
    // otherwise accept could not be true).
    assign load_sh   = accept & (~sh_busy | word_end);
    assign load_hold = accept & ~load_sh;

    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_shifted = {sh[WIDTH-2:0], 1'b0};
            assign sh_out     = sh[WIDTH-1];
        end else begin : g_lsb
            assign sh_shifted = {1'b0, sh[WIDTH-1:1]};
            assign sh_out     = sh[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sh        <= '0;
            sh_busy   <= 1'b0;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (word_end) begin
                cnt <= '0;
                if (hold_full) begin
                    sh        <= hold;
                    hold_full <= 1'b0;
                end else if (load_sh) begin
                    sh <= id;
                end else begin
                    // Fully shifted out, so sh ends up zero and sd idles at 0.
                    sh      <= sh_shifted;
                    sh_busy <= 1'b0;
                end
            end else if (beat) begin
                sh  <= sh_shifted;
                cnt <= cnt + 1'b1;
            end else if (load_sh) begin
                sh      <= id;
                sh_busy <= 1'b1;
                cnt     <= '0;
            end

            if (load_hold) begin
                hold      <= id;
                hold_full <= 1'b1;
            end
        end
    end

    assign sd       = sh_out;
    assign sd_valid = sh_busy;
    assign sd_first = sh_busy & (cnt == '0);
    assign sd_last  = sh_busy & (cnt == LAST_CNT);
    assign id_ready = ~hold_full;
    assign busy     = sh_busy | hold_full;

endmodule
